// File: rtl/fmap_streamer_4ch.sv
// ----------------------------------------------------------------------------
// fmap_streamer_4ch
//
// Purpose:
//   Holds one IMG_Width x IMG_Height frame for each of four channels and, on
//   request, streams the frame out in raster order with all four channel
//   pixels presented in parallel. The output feeds a 4-channel conv layer.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset (buffers are not cleared)
//   wr_en      buffer write strobe (honoured only while idle)
//   wr_ch      target channel 0..3
//   wr_addr    raster pixel index row*IMG_Width+col (>= NPIX is dropped)
//   wr_data    pixel value
//   start      single-cycle request to stream the buffered frame
//   pause      (only with FMAP_STREAM_PAUSE_EN) hold the stream for a cycle
//   Out_0..3   channel pixels, held while valid_out is low
//   valid_out  Out_0..Out_3 carry a freshly issued pixel
//   busy       high while the frame is being issued
//   done       one-cycle pulse in the cycle after the last valid pixel
//
// Configuration:
//   FMAP_STREAM_PAUSE_EN  adds the pause input. Left undefined, every
//                         streaming cycle issues a pixel.
//
// Timing: start sampled at edge T -> buffer read at edge T+1 -> Out_x and
// valid_out registered at edge T+2.
// ----------------------------------------------------------------------------
module fmap_streamer_4ch #(
    parameter int IMG_Width  = 3,
    parameter int IMG_Height = 3,
    parameter int Datawidth  = 32,
    localparam int NPIX      = IMG_Width * IMG_Height,
    localparam int ADDR_W    = (NPIX > 1) ? $clog2(NPIX) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [1:0]           wr_ch,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [Datawidth-1:0] wr_data,
    input  logic                 start,
`ifdef FMAP_STREAM_PAUSE_EN
    input  logic                 pause,
`endif
    output logic [Datawidth-1:0] Out_0,
    output logic [Datawidth-1:0] Out_1,
    output logic [Datawidth-1:0] Out_2,
    output logic [Datawidth-1:0] Out_3,
    output logic                 valid_out,
    output logic                 busy,
    output logic                 done
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    localparam logic [ADDR_W:0]   NPIX_W   = NPIX[ADDR_W:0];
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NPIX - 1);

    logic [0:0]           r_state;
    logic [ADDR_W-1:0]    r_cnt;
    logic [Datawidth-1:0] r_mem [4][NPIX];

    logic [Datawidth-1:0] r_pix_p0 [4];
    logic                 r_vld_p0;
    logic                 r_last_p0;
    logic                 r_last_p1;

    logic w_pause;
    logic w_issue;
    logic w_last;
    logic w_addr_ok;

`ifdef FMAP_STREAM_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    assign w_issue   = (r_state == S_STREAM) && !w_pause;
    assign w_last    = (r_cnt == LAST_IDX);
    assign w_addr_ok = ({1'b0, wr_addr} < NPIX_W);
    assign busy      = (r_state == S_STREAM);

    // Buffers: writes land only while idle, so a write in the same cycle as
    // start is already visible when pixel 0 is read one edge later.
    always_ff @(posedge clk) begin
        if (wr_en && (r_state == S_IDLE) && w_addr_ok) begin
            r_mem[wr_ch][wr_addr] <= wr_data;
        end
    end

    // Stage p0: synchronous buffer read of the issued pixel.
    always_ff @(posedge clk) begin
        if (w_issue) begin
            for (int c = 0; c < 4; c++) begin
                r_pix_p0[c] <= r_mem[c][r_cnt];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_vld_p0  <= 1'b0;
            r_last_p0 <= 1'b0;
            r_last_p1 <= 1'b0;
            valid_out <= 1'b0;
            done      <= 1'b0;
            Out_0     <= '0;
            Out_1     <= '0;
            Out_2     <= '0;
            Out_3     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_STREAM;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    if (w_issue) begin
                        if (w_last) begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
            endcase

            r_vld_p0  <= w_issue;
            r_last_p0 <= w_issue && w_last;

            // Stage p1: present the pixel; outputs hold when nothing new.
            valid_out <= r_vld_p0;
            r_last_p1 <= r_last_p0;
            if (r_vld_p0) begin
                Out_0 <= r_pix_p0[0];
                Out_1 <= r_pix_p0[1];
                Out_2 <= r_pix_p0[2];
                Out_3 <= r_pix_p0[3];
            end

            // Stage p2: end-of-frame pulse follows the last valid pixel.
            done <= r_last_p1;
        end
    end

endmodule

// File: tb/tb_fmap_streamer_4ch.sv
// ----------------------------------------------------------------------------
// tb_fmap_streamer_4ch
//
// Purpose:
//   Scoreboard bench for fmap_streamer_4ch (3x3, 32-bit). A frame model holds
//   what each channel buffer should contain; every accepted start pushes the
//   nine expected pixel vectors, and a monitor pops and compares whenever
//   valid_out is high. done, frame sums, latency and reset state are checked
//   too. With FMAP_STREAM_PAUSE_EN defined, pause is randomised mid-frame.
// ----------------------------------------------------------------------------
module tb_fmap_streamer_4ch;

    localparam int NP = 9;

    typedef struct packed {
        logic [3:0][31:0] px;
        logic             last;
        logic [31:0]      sum;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        start;
    logic        pause;
    logic [31:0] Out_0, Out_1, Out_2, Out_3;
    logic        valid_out;
    logic        busy;
    logic        done;

    fmap_streamer_4ch #(
        .IMG_Width (3),
        .IMG_Height(3),
        .Datawidth (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_ch    (wr_ch),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .start    (start),
`ifdef FMAP_STREAM_PAUSE_EN
        .pause    (pause),
`endif
        .Out_0    (Out_0),
        .Out_1    (Out_1),
        .Out_2    (Out_2),
        .Out_3    (Out_3),
        .valid_out(valid_out),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m_mem [4][NP];
    exp_t        q[$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: checks pixels against the queue, done placement and frame sum.
    logic        exp_done = 1'b0;
    logic [31:0] acc = '0;
    always @(negedge clk) begin
        exp_t e;
        logic nxt_done;
        nxt_done = 1'b0;
        if (rst) begin
            acc = '0;
        end else begin
            if (done || exp_done) check("done_pulse", {31'd0, done}, {31'd0, exp_done});
            if (valid_out) begin
                if (q.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("out0", Out_0, e.px[0]);
                    check("out1", Out_1, e.px[1]);
                    check("out2", Out_2, e.px[2]);
                    check("out3", Out_3, e.px[3]);
                    acc = acc + Out_0 + Out_1 + Out_2 + Out_3;
                    if (e.last) begin
                        check("conv_sum", acc + 32'd1, e.sum);
                        acc = '0;
                        nxt_done = 1'b1;
                    end
                end
            end
        end
        exp_done = nxt_done;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int addr, input logic [31:0] d, input bit apply);
        wr_en   = 1'b1;
        wr_ch   = 2'(ch);
        wr_addr = 4'(addr);
        wr_data = d;
        if (apply && addr < NP) m_mem[ch][addr] = d;
        step();
        wr_en = 1'b0;
    endtask

    // Pulse start (optionally with a same-cycle write) and push the frame.
    task automatic start_frame(input bit chk_lat, input bit do_w, input int ch,
                               input int addr, input logic [31:0] d);
        exp_t e;
        logic [31:0] s;
        start = 1'b1;
        pause = 1'b0;
        if (do_w) begin
            wr_en   = 1'b1;
            wr_ch   = 2'(ch);
            wr_addr = 4'(addr);
            wr_data = d;
            if (addr < NP) m_mem[ch][addr] = d;
        end
        s = 32'd1;
        for (int i = 0; i < NP; i++)
            for (int c = 0; c < 4; c++) s = s + m_mem[c][i];
        for (int i = 0; i < NP; i++) begin
            for (int c = 0; c < 4; c++) e.px[c] = m_mem[c][i];
            e.last = (i == NP - 1);
            e.sum  = s;
            q.push_back(e);
        end
        step();                         // edge T samples start
        start = 1'b0;
        wr_en = 1'b0;
        step();                         // edge T+1
        if (chk_lat) begin
            check("lat_t1_valid", {31'd0, valid_out}, 32'd0);
            check("busy_stream", {31'd0, busy}, 32'd1);
        end
        step();                         // edge T+2
        if (chk_lat) check("lat_t2_valid", {31'd0, valid_out}, 32'd1);
    endtask

    // Wait for done; returns with done high (the done cycle).
    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
`ifdef FMAP_STREAM_PAUSE_EN
            pause = ($urandom_range(0, 3) == 0);
`endif
            step();
            if (done) seen = 1'b1;
        end
        pause = 1'b0;
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_addr = '0; wr_data = '0;
        start = 1'b0; pause = 1'b0;
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < NP; i++) m_mem[c][i] = 'x;
        step(); step();
        check("rst_out0", Out_0, 32'd0);
        check("rst_out3", Out_3, 32'd0);
        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        step();

        // Reference frame 16*c+i, plus an out-of-range write.
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < NP; i++) wr(c, i, 32'(16 * c + i), 1'b1);
        wr(0, 9, 32'hDEAD, 1'b1);
        start_frame(1'b1, 1'b0, 0, 0, '0);
        wait_done();

        // Restart in the done cycle; write and start during the stream.
        start_frame(1'b1, 1'b0, 0, 0, '0);
        wr(0, 4, 32'hBEEF, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done();
        start_frame(1'b1, 1'b0, 0, 0, '0);   // again from the done cycle
        wait_done();
        step(); step();

        // Reset after the 4th valid pixel; buffers must survive.
        start_frame(1'b1, 1'b0, 0, 0, '0);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        q.delete();
        check("mrst_out0", Out_0, 32'd0);
        check("mrst_out2", Out_2, 32'd0);
        check("mrst_valid", {31'd0, valid_out}, 32'd0);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_done", {31'd0, done}, 32'd0);
        repeat (5) step();
        start_frame(1'b1, 1'b0, 0, 0, '0);
        wait_done();

        // Randomised frames with same-cycle write+start mixed in.
        for (int it = 0; it < 8; it++) begin
            int nw;
            step();
            nw = $urandom_range(2, 8);
            for (int k = 0; k < nw; k++)
                wr($urandom_range(0, 3), $urandom_range(0, 11), $urandom, 1'b1);
            start_frame(1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 3),
                        $urandom_range(0, 10), $urandom);
            wait_done();
        end

        repeat (4) step();
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
